// File: rtl/frl_multiport.sv
// Free register list: circular FIFO of free physical tags, multi-port.
// Define FRL_PROTOCOL_CHECK_EN to enable the sticky Frl_Err checker.
module frl_multiport #(
  parameter int PHY_W      = 6,
  parameter int DEPTH      = 16,
  parameter int FIRST_FREE = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1,
  localparam int CNT_W = IDX_W + 1,
  localparam int RC_W  = $clog2(RD_PORTS + 1)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Cdb_Flush,
  input  logic [PTR_W-1:0]          Cfc_FrlHeadPtr,
  input  logic [WR_PORTS-1:0]       Rob_Commit,
  input  logic [WR_PORTS-1:0]       Rob_CommitRegWrite,
  input  logic [WR_PORTS*PHY_W-1:0] Rob_CommitPrePhyAddr,
  input  logic [RC_W-1:0]           Dis_FrlReadCnt,
  output logic [RD_PORTS*PHY_W-1:0] Frl_RdPhyAddr,
  output logic [RC_W-1:0]           Frl_AvailCnt,
  output logic [CNT_W-1:0]          Frl_Count,
  output logic                      Frl_Empty,
  output logic [PTR_W-1:0]          Frl_HeadPtr,
  output logic                      Frl_Err
);

  logic [PHY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] space;
  logic [PTR_W-1:0] wr_n;
  logic [PTR_W-1:0] tail_nxt;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] rp;
  logic [PTR_W-1:0] wp;
  logic [RC_W-1:0]  rd_n;
  logic [WR_PORTS-1:0] wen;
  logic [IDX_W-1:0] widx [WR_PORTS];
  logic [WR_PORTS-1:0] valid;

  assign count       = tail - head;
  assign space       = PTR_W'(DEPTH) - count;
  assign valid       = Rob_Commit & Rob_CommitRegWrite;
  assign Frl_Count   = CNT_W'(count);
  assign Frl_Empty   = (count == '0);
  assign Frl_HeadPtr = head;

  always_comb begin
    Frl_AvailCnt = RC_W'(RD_PORTS);
    if (count < PTR_W'(RD_PORTS))
      Frl_AvailCnt = RC_W'(count);
  end

  always_comb begin
    Frl_RdPhyAddr = '0;
    rp = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      rp = head + PTR_W'(j);
      Frl_RdPhyAddr[j*PHY_W +: PHY_W] = mem[rp[IDX_W-1:0]];
    end
  end

  // Over-requests saturate to what is actually available.
  assign rd_n = (Dis_FrlReadCnt < Frl_AvailCnt) ? Dis_FrlReadCnt
                                                : Frl_AvailCnt;
  assign head_nxt = Cdb_Flush ? Cfc_FrlHeadPtr
                              : head + PTR_W'(rd_n);

`ifdef FRL_PROTOCOL_CHECK_EN
  logic drop;
`endif

  // Compact valid commit ports onto consecutive tail slots until full.
  always_comb begin
    wr_n = '0;
    wp   = '0;
    wen  = '0;
`ifdef FRL_PROTOCOL_CHECK_EN
    drop = 1'b0;
`endif
    for (int k = 0; k < WR_PORTS; k++) begin
      widx[k] = '0;
      if (valid[k]) begin
        if (wr_n < space) begin
          wp      = tail + wr_n;
          wen[k]  = 1'b1;
          widx[k] = wp[IDX_W-1:0];
          wr_n    = wr_n + 1'b1;
        end
`ifdef FRL_PROTOCOL_CHECK_EN
        else drop = 1'b1;
`endif
      end
    end
    tail_nxt = tail + wr_n;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head <= '0;
      tail <= PTR_W'(DEPTH);
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= PHY_W'(FIRST_FREE + i);
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      for (int k = 0; k < WR_PORTS; k++)
        if (wen[k])
          mem[widx[k]] <= Rob_CommitPrePhyAddr[k*PHY_W +: PHY_W];
    end
  end

`ifdef FRL_PROTOCOL_CHECK_EN
  logic err_q;
  logic ev_rd;
  logic ev_fl;

  assign ev_rd = !Cdb_Flush && (Dis_FrlReadCnt > Frl_AvailCnt);
  assign ev_fl = Cdb_Flush &&
                 ((tail_nxt - Cfc_FrlHeadPtr) > PTR_W'(DEPTH));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else if (ev_rd || drop || ev_fl) begin
      err_q <= 1'b1;
`ifndef SYNTHESIS
      if (ev_rd) $error("frl: read count exceeds available");
      if (drop)  $error("frl: commit write dropped on full list");
      if (ev_fl) $error("frl: flush head pointer beyond depth");
`endif
    end
  end

  assign Frl_Err = err_q;
`else
  assign Frl_Err = 1'b0;
`endif

endmodule

// File: tb/tb_frl_multiport.sv
// Directed self-checking bench for frl_multiport (default parameters).
module tb_frl_multiport;

  localparam int PHY_W = 6;
`ifdef FRL_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Cdb_Flush;
  logic [4:0]   Cfc_FrlHeadPtr;
  logic [1:0]   Rob_Commit;
  logic [1:0]   Rob_CommitRegWrite;
  logic [11:0]  Rob_CommitPrePhyAddr;
  logic [1:0]   Dis_FrlReadCnt;
  logic [11:0]  Frl_RdPhyAddr;
  logic [1:0]   Frl_AvailCnt;
  logic [4:0]   Frl_Count;
  logic         Frl_Empty;
  logic [4:0]   Frl_HeadPtr;
  logic         Frl_Err;

  int checks = 0;
  int failures = 0;

  frl_multiport dut (
    .Clk                  (Clk),
    .Reset                (Reset),
    .Cdb_Flush            (Cdb_Flush),
    .Cfc_FrlHeadPtr       (Cfc_FrlHeadPtr),
    .Rob_Commit           (Rob_Commit),
    .Rob_CommitRegWrite   (Rob_CommitRegWrite),
    .Rob_CommitPrePhyAddr (Rob_CommitPrePhyAddr),
    .Dis_FrlReadCnt       (Dis_FrlReadCnt),
    .Frl_RdPhyAddr        (Frl_RdPhyAddr),
    .Frl_AvailCnt         (Frl_AvailCnt),
    .Frl_Count            (Frl_Count),
    .Frl_Empty            (Frl_Empty),
    .Frl_HeadPtr          (Frl_HeadPtr),
    .Frl_Err              (Frl_Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    Cdb_Flush = 1'b0;
    Cfc_FrlHeadPtr = '0;
    Rob_Commit = '0;
    Rob_CommitRegWrite = '0;
    Rob_CommitPrePhyAddr = '0;
    Dis_FrlReadCnt = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic commit(input logic [1:0] c, input logic [1:0] w,
                        input int t0, input int t1);
    Rob_Commit = c;
    Rob_CommitRegWrite = w;
    Rob_CommitPrePhyAddr = {PHY_W'(t1), PHY_W'(t0)};
  endtask

  function automatic int slot(input int j);
    return int'(Frl_RdPhyAddr[j*PHY_W +: PHY_W]);
  endfunction

  initial begin
    idle();
    Reset = 1'b1;
    @(negedge Clk);
    do_reset();

    chk("rst_slot0", slot(0), 32);
    chk("rst_slot1", slot(1), 33);
    chk("rst_count", Frl_Count, 16);
    chk("rst_avail", Frl_AvailCnt, 2);
    chk("rst_empty", Frl_Empty, 0);
    chk("rst_head", Frl_HeadPtr, 0);
    chk("rst_err", Frl_Err, 0);

    for (int c = 0; c < 8; c++) begin
      chk("drain_slot0", slot(0), 32 + 2*c);
      chk("drain_slot1", slot(1), 33 + 2*c);
      Dis_FrlReadCnt = 2'd2;
      tick();
    end
    chk("empty_count", Frl_Count, 0);
    chk("empty_flag", Frl_Empty, 1);
    chk("empty_avail", Frl_AvailCnt, 0);
    chk("empty_head", Frl_HeadPtr, 16);

    // port1 RegWrite=0; read of 1 on empty list saturates to 0
    commit(2'b11, 2'b01, 40, 41);
    Dis_FrlReadCnt = 2'd1;
    tick();
    chk("c1_count", Frl_Count, 1);
    chk("c1_slot0", slot(0), 40);
    chk("c1_avail", Frl_AvailCnt, 1);
    chk("c1_head", Frl_HeadPtr, 16);

    commit(2'b11, 2'b10, 50, 51);
    tick();
    chk("c2_count", Frl_Count, 2);
    chk("c2_slot1", slot(1), 51);

    commit(2'b10, 2'b11, 0, 52);
    tick();
    commit(2'b01, 2'b11, 53, 0);
    tick();
    commit(2'b11, 2'b11, 54, 55);
    tick();
    chk("c5_count", Frl_Count, 6);

    Dis_FrlReadCnt = 2'd2;
    tick();
    chk("rd_slot0", slot(0), 52);
    chk("rd_slot1", slot(1), 53);
    Dis_FrlReadCnt = 2'd2;
    tick();
    chk("rd2_slot0", slot(0), 54);
    chk("rd2_slot1", slot(1), 55);
    chk("rd2_head", Frl_HeadPtr, 20);

    // flush with concurrent commit
    do_reset();
    Dis_FrlReadCnt = 2'd2; tick();
    Dis_FrlReadCnt = 2'd2; tick();
    Dis_FrlReadCnt = 2'd1; tick();
    chk("pre_fl_head", Frl_HeadPtr, 5);
    Cdb_Flush = 1'b1;
    Cfc_FrlHeadPtr = 5'd2;
    Dis_FrlReadCnt = 2'd2;
    commit(2'b01, 2'b01, 60, 0);
    tick();
    chk("fl_head", Frl_HeadPtr, 2);
    chk("fl_slot0", slot(0), 34);
    chk("fl_slot1", slot(1), 35);
    chk("fl_count", Frl_Count, 15);

    // commit on a full list is dropped
    do_reset();
    commit(2'b01, 2'b01, 61, 0);
    tick();
    chk("full_count", Frl_Count, 16);
    chk("full_slot0", slot(0), 32);
    chk("full_err", Frl_Err, EXP_ERR);
    tick();
    chk("full_err_sticky", Frl_Err, EXP_ERR);
    do_reset();
    chk("err_clr", Frl_Err, 0);
    chk("err_clr_count", Frl_Count, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frl_multiport.md
Name: frl_multiport

Overview:
- Parametrised free register list for the superscalar physical register file: a circular FIFO of free physical tags.
- Hands out up to RD_PORTS tags per cycle to dispatch.
- Accepts up to WR_PORTS released tags per cycle from ROB commit.
- Restores its head pointer from the checkpoint (CFC) stack on a CDB flush.

Parameters:
- PHY_W, 6, physical tag width.
- DEPTH, 16, list entries; power of 2, ≥ RD_PORTS and ≥ WR_PORTS.
- FIRST_FREE, 32, tag held in entry 0 at reset (entry i holds FIRST_FREE+i).
- RD_PORTS, 2, tags dispatchable per cycle.
- WR_PORTS, 2, tags releasable per cycle.
- Derived: PTR_W = log2(DEPTH)+1 (extra wrap bit); CNT_W = log2(DEPTH)+1; RC_W = clog2(RD_PORTS+1).

Ports:
- Clk  in  1  clock; all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Cdb_Flush  in  1  flush: reload head from Cfc_FrlHeadPtr.
- Cfc_FrlHeadPtr  in  PTR_W  checkpointed head pointer.
- Rob_Commit  in  WR_PORTS  per-port commit valid.
- Rob_CommitRegWrite  in  WR_PORTS  per-port "instruction wrote a register".
- Rob_CommitPrePhyAddr  in  WR_PORTS*PHY_W  per-port previous tag to free; port k in bits [k*PHY_W +: PHY_W].
- Dis_FrlReadCnt  in  RC_W  number of tags consumed this cycle (0..RD_PORTS).
- Frl_RdPhyAddr  out  RD_PORTS*PHY_W  slot j = mem[(head+j) mod DEPTH], combinational.
- Frl_AvailCnt  out  RC_W  min(count, RD_PORTS).
- Frl_Count  out  CNT_W  occupancy = tail − head (PTR_W arithmetic).
- Frl_Empty  out  1  count == 0.
- Frl_HeadPtr  out  PTR_W  current head, for checkpoint push.
- Frl_Err  out  1  sticky protocol-error flag (see Optional Feature).

Behaviour:
- Reset (synchronous, priority over everything):
  - mem[i] ← FIRST_FREE+i.
  - head ← 0; tail ← DEPTH (wrap bit set, low bits 0).
  - Hence Frl_Count = DEPTH, Frl_Empty = 0, Frl_AvailCnt = RD_PORTS, Frl_HeadPtr = 0, Frl_Err = 0.
  - Reset mid-operation discards all in-flight reads, commits and flush in that cycle.
- Pointer arithmetic: modulo 2^PTR_W; memory index = low log2(DEPTH) bits.
- Read side (head):
  - Cdb_Flush=1: head ← Cfc_FrlHeadPtr; Dis_FrlReadCnt ignored that cycle.
  - Otherwise: head ← head + rd, where rd = min(Dis_FrlReadCnt, Frl_AvailCnt). Over-request saturates; it never underflows.
  - Read data is combinational from the current head; 0-cycle latency.
  - Slots j ≥ count present stale data; dispatch must honour Frl_AvailCnt.
- Write side (tail), independent of and concurrent with the read side (flush does not block commits):
  - Port k is valid iff Rob_Commit[k] & Rob_CommitRegWrite[k].
  - Valid ports are compacted in ascending port order: the n-th valid port (n from 0) writes mem[(tail+n) mod DEPTH].
  - tail ← tail + number of accepted writes.
  - A write that would make count exceed DEPTH is dropped; tail saturates at head+DEPTH. Ports are accepted in order until full.
- Same cycle read + write:
  - Occupancy after the edge = count − rd + wr.
  - Tags written this cycle are not readable until the next cycle, even when count was 0.
  - Frl_AvailCnt uses pre-edge count only.
- Flush + commit same cycle: head restored, tail advanced by commits; count = tail_new − Cfc_FrlHeadPtr.
- Wrap-around: head and tail wrap independently. Full ⇔ low bits equal and wrap bits differ. Empty ⇔ all PTR_W bits equal.

Optional Feature:
- Macro: FRL_PROTOCOL_CHECK_EN.
- Defined: Frl_Err is set (sticky until Reset) on any of:
  - Dis_FrlReadCnt > Frl_AvailCnt without flush;
  - a dropped commit write (overflow);
  - Cfc_FrlHeadPtr with (tail_new − Cfc_FrlHeadPtr) > DEPTH at flush.
  - Plus a simulation-only $error on each event.
- Not defined: Frl_Err tied to 0, no checker logic; the saturation behaviour above is unchanged.

Test Plan:
- Reset, defaults (DEPTH=16, RD=WR=2) → Frl_RdPhyAddr slots 32,33; Count=16; AvailCnt=2; Empty=0; HeadPtr=0.
- Dis_FrlReadCnt=2 for 8 cycles → slots step 32/33, 34/35, … 46/47. Then Count=0, Empty=1, AvailCnt=0, HeadPtr=16 (0x10).
- From empty: commit ports 0,1 valid with RegWrite=1,0 and tag 40 on port 0 → next cycle Count=1, slot0=40, AvailCnt=1. Same-cycle Dis_FrlReadCnt=1 was saturated to 0.
- Both commit ports valid (tags 50,51) with port0 RegWrite=0 → only 51 written at tail; then port1-only/port0-only orders verified as compacted.
- After reading 5 tags (HeadPtr=5): assert Cdb_Flush with Cfc_FrlHeadPtr=2 and one commit (tag 60) → HeadPtr=2, slot0=34, Count=15.
- With FRL_PROTOCOL_CHECK_EN at reset state (full): commit one tag → write dropped, Count stays 16, Frl_Err=1 and remains 1 until Reset. Without the macro, same stimulus gives Frl_Err=0.
